// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexed N-digit BCD display scanner with dead time and leading-zero blanking
module bcd_display_scanner #(
  parameter int DIGITS = 4,
  parameter int DIV = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [4*DIGITS-1:0]           digits_in,
  input  logic [DIGITS-1:0]             dp_in,
  input  logic                          lz_blank,
  output logic [3:0]                    bcd,
  output logic                          dp,
  output logic [DIGITS-1:0]             an,
  output logic [(DIGITS>2 ? $clog2(DIGITS) : 1)-1:0] sel,
  output logic                          frame_start
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = DIGITS > 2 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK_CYCLES);
  localparam logic [SW-1:0] SMAX = SW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] OFF = {DIGITS{AN_ACTIVE_LOW != 0}};
  logic [CW-1:0] cnt;
  logic [SW-1:0] sel_q;
  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0] shadow_dp;
  logic first_load;
  logic wrap_q;
  logic [DIGITS-1:0] zero_from;
  logic [DIGITS-1:0] onehot;
  logic [DIGITS-1:0] lit;
  logic [3:0] nib;
  logic blank;
  logic slot_end;
  logic boundary;
  // zero_from[i]: shadow digits i..DIGITS-1 are all zero
  always_comb begin
    zero_from = '0;
    for (int i = 0; i < DIGITS; i++) zero_from[i] = (shadow >> (4 * i)) == '0;
  end
  always_comb begin
    nib = shadow[4*sel_q +: 4];
    blank = lz_blank && sel_q != '0 && zero_from[sel_q];
    onehot = DIGITS'(1) << sel_q;
    lit = AN_ACTIVE_LOW != 0 ? ~onehot : onehot;
    slot_end = cnt == LAST;
    boundary = slot_end && sel_q == SMAX;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sel_q <= '0;
      shadow <= '0;
      shadow_dp <= '0;
      first_load <= 1'b1;
      wrap_q <= 1'b0;
      bcd <= '0;
      dp <= 1'b0;
      an <= OFF;
      sel <= '0;
      frame_start <= 1'b0;
    end else begin
      wrap_q <= en && !first_load && boundary;
      frame_start <= wrap_q;
      sel <= sel_q;
      if (en) begin
        cnt <= slot_end ? '0 : cnt + 1'b1;
        if (slot_end) sel_q <= sel_q == SMAX ? '0 : sel_q + 1'b1;
        if (first_load || boundary) begin
          shadow <= digits_in;
          shadow_dp <= dp_in;
        end
        first_load <= 1'b0;
        bcd <= blank ? 4'd0 : nib;
        dp <= !blank && shadow_dp[sel_q];
        an <= (cnt < BL || blank) ? OFF : lit;
      end else begin
        an <= OFF;
      end
    end
  end
endmodule
